// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard unit: forward-select codes,
// the load result-source code and the long-op scoreboard state type.
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM ALU result

  localparam logic [1:0] RES_SRC_LOAD = 2'b01;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one EX operand. MEM has priority over WB because it
// holds the younger write; x0 is never forwarded.
module hazard_fwd_sel #(
  parameter int RA_W   = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] rd_m,
  input  logic            regwrite_m,
  input  logic [RA_W-1:0] rd_w,
  input  logic            regwrite_w,
  output logic [1:0]      fwd_sel
);
  import pipe_pkg::*;

  // Pick the youngest in-flight producer of rs, or the register file.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the output
    // unassigned; otherwise synthesis infers a latch.
    fwd_sel = FWD_REG;
    if (FWD_EN && (rs != '0)) begin
      if (regwrite_m && (rd_m == rs)) begin
        fwd_sel = FWD_MEM;
      end else if (regwrite_w && (rd_w == rs)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: load-use / no-forward stalls, branch
// flush, EX forwarding, a one-entry scoreboard for the long-latency unit with
// a watchdog, and a saturating count of ID stall cycles.
module hazard_scoreboard #(
  parameter int RA_W    = 5,
  parameter bit FWD_EN  = 1'b1,
  parameter int MAX_LAT = 34,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  rs1_d,
  input  logic [RA_W-1:0]  rs2_d,
  input  logic [RA_W-1:0]  rd_d,
  input  logic             regwrite_d,
  input  logic             long_op_d,
  input  logic [RA_W-1:0]  rs1_e,
  input  logic [RA_W-1:0]  rs2_e,
  input  logic [RA_W-1:0]  rd_e,
  input  logic             regwrite_e,
  input  logic [1:0]       result_src_e,
  input  logic             pc_src_e,
  input  logic             long_issue_e,
  input  logic             long_done,
  input  logic [RA_W-1:0]  rd_m,
  input  logic             regwrite_m,
  input  logic [RA_W-1:0]  rd_w,
  input  logic             regwrite_w,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             sb_busy,
  output logic [RA_W-1:0]  sb_rd,
  output logic             sb_err,
  output logic [CNT_W-1:0] stall_cnt
);
  import pipe_pkg::*;

  localparam int LAT_W = $clog2(MAX_LAT + 1);

  sb_state_e        state_q, state_d;
  logic [RA_W-1:0]  sb_rd_q, sb_rd_d;
  logic [LAT_W-1:0] wdog_q, wdog_d;
  logic             sb_err_q, sb_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       busy, accept, hazard;
  logic       load_use, nofwd_raw, sb_raw, sb_waw, sb_struct;

  // True when r is a real register read by the ID instruction.
  function automatic logic reads_reg(input logic [RA_W-1:0] r,
                                     input logic [RA_W-1:0] a,
                                     input logic [RA_W-1:0] b);
    return (r != '0) && ((r == a) || (r == b));
  endfunction

  hazard_fwd_sel #(.RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_a (
    .rs(rs1_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .fwd_sel(fwd_a_raw)
  );

  hazard_fwd_sel #(.RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_b (
    .rs(rs2_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .fwd_sel(fwd_b_raw)
  );

  // A long op with rd=x0 has nothing to track, so it never occupies the entry.
  assign busy   = (state_q == SB_BUSY);
  assign accept = long_issue_e && (rd_e != '0);

  // Individual stall causes; only the registered busy bit is used so a
  // dependent instruction leaves ID the cycle after long_done.
  always_comb begin
    load_use  = (result_src_e == RES_SRC_LOAD) && reads_reg(rd_e, rs1_d, rs2_d);
    nofwd_raw = !FWD_EN && ((regwrite_e && reads_reg(rd_e, rs1_d, rs2_d)) ||
                            (regwrite_m && reads_reg(rd_m, rs1_d, rs2_d)));
    sb_raw    = busy && reads_reg(sb_rd_q, rs1_d, rs2_d);
    sb_waw    = busy && regwrite_d && (rd_d != '0) && (rd_d == sb_rd_q);
    sb_struct = busy && long_op_d;
    hazard    = load_use || nofwd_raw || sb_raw || sb_waw || sb_struct;
  end

  // Combine stalls and flushes; reset flushes, a taken branch beats any stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hazard) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Forward selects are held at register-file while in reset.
  always_comb begin
    fwd_a_e = reset ? FWD_REG : fwd_a_raw;
    fwd_b_e = reset ? FWD_REG : fwd_b_raw;
  end

  // Scoreboard FSM with watchdog; a completion frees the entry before a
  // same-cycle issue is considered.
  always_comb begin
    state_d  = state_q;
    sb_rd_d  = sb_rd_q;
    wdog_d   = wdog_q;
    sb_err_d = sb_err_q;
    case (state_q)
      SB_IDLE: begin
        if (accept) begin
          state_d = SB_BUSY;
          sb_rd_d = rd_e;
          wdog_d  = '0;
        end
      end
      SB_BUSY: begin
        if (long_done) begin
          state_d = accept ? SB_BUSY : SB_IDLE;
          wdog_d  = '0;
          if (accept) sb_rd_d = rd_e;
        end else begin
          if (long_issue_e) sb_err_d = 1'b1;
          if (wdog_q == LAT_W'(MAX_LAT)) begin
            sb_err_d = 1'b1;
            state_d  = SB_IDLE;
          end else begin
            wdog_d = wdog_q + LAT_W'(1);
          end
        end
      end
    endcase
  end

  // Saturating count of cycles in which ID is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= SB_IDLE;
      sb_rd_q     <= '0;
      wdog_q      <= '0;
      sb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sb_rd_q     <= sb_rd_d;
      wdog_q      <= wdog_d;
      sb_err_q    <= sb_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb_busy   = busy;
  assign sb_rd     = sb_rd_q;
  assign sb_err    = sb_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: instance 0 uses defaults (forwarding on,
// MAX_LAT=34, 16-bit counter); instance 1 has forwarding off, MAX_LAT=6 and a
// 3-bit counter so watchdog expiry and counter saturation occur often.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic regwrite_d, long_op_d, regwrite_e, pc_src_e, long_issue_e, long_done;
  logic regwrite_m, regwrite_w;
  logic [1:0] result_src_e;

  logic [1:0] stall_f_o, stall_d_o, flush_d_o, flush_e_o, sb_busy_o, sb_err_o;
  logic [1:0] fwd_a_o [2];
  logic [1:0] fwd_b_o [2];
  logic [4:0] sb_rd_o [2];
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int errors = 0;
  int n_checks = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  hazard_scoreboard dut0 (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d), .long_op_d(long_op_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .regwrite_e(regwrite_e),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e), .long_issue_e(long_issue_e),
    .long_done(long_done), .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w),
    .regwrite_w(regwrite_w),
    .stall_f(stall_f_o[0]), .stall_d(stall_d_o[0]), .flush_d(flush_d_o[0]),
    .flush_e(flush_e_o[0]), .fwd_a_e(fwd_a_o[0]), .fwd_b_e(fwd_b_o[0]),
    .sb_busy(sb_busy_o[0]), .sb_rd(sb_rd_o[0]), .sb_err(sb_err_o[0]), .stall_cnt(cnt0)
  );

  hazard_scoreboard #(.FWD_EN(1'b0), .MAX_LAT(6), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d), .long_op_d(long_op_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .regwrite_e(regwrite_e),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e), .long_issue_e(long_issue_e),
    .long_done(long_done), .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w),
    .regwrite_w(regwrite_w),
    .stall_f(stall_f_o[1]), .stall_d(stall_d_o[1]), .flush_d(flush_d_o[1]),
    .flush_e(flush_e_o[1]), .fwd_a_e(fwd_a_o[1]), .fwd_b_e(fwd_b_o[1]),
    .sb_busy(sb_busy_o[1]), .sb_rd(sb_rd_o[1]), .sb_err(sb_err_o[1]), .stall_cnt(cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outstanding long op: its register and the clock edge on which it was
  // accepted; the watchdog fires MAX_LAT+1 edges after acceptance.
  typedef struct {
    bit     busy;
    int     rd;
    longint since;
    bit     err;
    int     cnt;
  } mdl_t;

  mdl_t   m [2];
  longint edge_n = 0;

  function automatic int ml(input int i);   return (i == 0) ? 34 : 6;     endfunction
  function automatic int cmax(input int i); return (i == 0) ? 65535 : 7;  endfunction
  function automatic bit fw(input int i);   return (i == 0);              endfunction

  function automatic bit uses(input int r);
    return (r != 0) && ((r == int'(rs1_d)) || (r == int'(rs2_d)));
  endfunction

  function automatic int exp_fwd(input int i, input int rs);
    if (reset || !fw(i) || rs == 0) return 0;
    if (regwrite_m && int'(rd_m) == rs) return 2;
    if (regwrite_w && int'(rd_w) == rs) return 1;
    return 0;
  endfunction

  function automatic bit exp_hazard(input int i);
    bit h;
    h = (result_src_e == 2'b01) && uses(int'(rd_e));
    if (!fw(i)) h = h || (regwrite_e && uses(int'(rd_e))) || (regwrite_m && uses(int'(rd_m)));
    if (m[i].busy)
      h = h || uses(m[i].rd) || (regwrite_d && int'(rd_d) == m[i].rd) || long_op_d;
    return h;
  endfunction

  function automatic bit exp_stall(input int i);
    return !reset && !pc_src_e && exp_hazard(i);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) m[i] = '{busy: 1'b0, rd: 0, since: 0, err: 1'b0, cnt: 0};
    end else begin
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        bit st;
        st = exp_stall(i);
        if (st && m[i].cnt < cmax(i)) m[i].cnt++;
        if (m[i].busy && !long_done) begin
          if (long_issue_e) m[i].err = 1'b1;
          if (edge_n - m[i].since == longint'(ml(i) + 1)) begin
            m[i].busy = 1'b0;
            m[i].err  = 1'b1;
          end
        end else if (long_issue_e && rd_e != 5'd0) begin
          m[i].busy  = 1'b1;
          m[i].rd    = int'(rd_e);
          m[i].since = edge_n;
        end else begin
          m[i].busy = 1'b0;
        end
      end
    end
  end

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge clk) begin
    logic [31:0] cnt_act;
    bit st;
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        st = exp_stall(i);
        cnt_act = (i == 0) ? 32'(cnt0) : 32'(cnt1);
        check($sformatf("stall_f[%0d]", i), 32'(stall_f_o[i]), 32'(st));
        check($sformatf("stall_d[%0d]", i), 32'(stall_d_o[i]), 32'(st));
        check($sformatf("flush_d[%0d]", i), 32'(flush_d_o[i]), 32'(reset || pc_src_e));
        check($sformatf("flush_e[%0d]", i), 32'(flush_e_o[i]), 32'(reset || pc_src_e || st));
        check($sformatf("fwd_a[%0d]", i), 32'(fwd_a_o[i]), 32'(exp_fwd(i, int'(rs1_e))));
        check($sformatf("fwd_b[%0d]", i), 32'(fwd_b_o[i]), 32'(exp_fwd(i, int'(rs2_e))));
        check($sformatf("sb_busy[%0d]", i), 32'(sb_busy_o[i]), 32'(m[i].busy));
        check($sformatf("sb_err[%0d]", i), 32'(sb_err_o[i]), 32'(m[i].err));
        check($sformatf("stall_cnt[%0d]", i), cnt_act, 32'(m[i].cnt));
        if (m[i].busy && !reset) check($sformatf("sb_rd[%0d]", i), 32'(sb_rd_o[i]), 32'(m[i].rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rd_d = '0; regwrite_d = 1'b0; long_op_d = 1'b0;
    rs1_e = '0; rs2_e = '0; rd_e = '0; regwrite_e = 1'b0; result_src_e = 2'b00;
    pc_src_e = 1'b0; long_issue_e = 1'b0; long_done = 1'b0;
    rd_m = '0; regwrite_m = 1'b0; rd_w = '0; regwrite_w = 1'b0;
  endtask

  initial begin
    int n;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("rst_flush_d", flush_d_o[0], 1);
    check("rst_flush_e", flush_e_o[0], 1);
    check("rst_stall_d", stall_d_o[0], 0);
    check("rst_busy", sb_busy_o[0], 0);
    check("rst_cnt", cnt0, 0);
    run = 1'b1;
    tick();
    reset = 1'b0;

    // Forwarding: MEM only, WB only, both, x0.
    tick(); rs1_e = 5'd5; regwrite_m = 1'b1; rd_m = 5'd5; #1;
    check("fwd_mem", fwd_a_o[0], 2'b10);
    check("fwd_nofwd_inst", fwd_a_o[1], 2'b00);
    tick(); regwrite_m = 1'b0; regwrite_w = 1'b1; rd_w = 5'd5; #1;
    check("fwd_wb", fwd_a_o[0], 2'b01);
    tick(); regwrite_m = 1'b1; #1;
    check("fwd_both", fwd_a_o[0], 2'b10);
    tick(); rs1_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0; #1;
    check("fwd_x0", fwd_a_o[0], 2'b00);
    tick(); rd_w = 5'd9; rs2_e = 5'd9; regwrite_m = 1'b0; #1;
    check("fwd_b_wb", fwd_b_o[0], 2'b01);

    // Load-use: lw x6 in EX, add x7,x6,x1 in ID.
    tick(); clear_inputs();
    result_src_e = 2'b01; regwrite_e = 1'b1; rd_e = 5'd6;
    rd_d = 5'd7; rs1_d = 5'd6; rs2_d = 5'd1; regwrite_d = 1'b1; #1;
    check("lu_stall_f", stall_f_o[0], 1);
    check("lu_stall_d", stall_d_o[0], 1);
    check("lu_flush_e", flush_e_o[0], 1);
    check("lu_flush_d", flush_d_o[0], 0);
    tick(); result_src_e = 2'b00; regwrite_e = 1'b0; rd_e = 5'd0; #1;
    check("lu_release", stall_d_o[0], 0);
    check("lu_cnt", cnt0, 1);

    // div x8, dependent reader stalls until the cycle after long_done.
    tick(); clear_inputs(); long_issue_e = 1'b1; rd_e = 5'd8;
    tick(); long_issue_e = 1'b0; rd_e = 5'd0; rs1_d = 5'd8; #1;
    check("div_busy", sb_busy_o[0], 1);
    check("div_rd", sb_rd_o[0], 8);
    check("div_stall", stall_d_o[0], 1);
    repeat (8) tick();
    tick(); long_done = 1'b1; #1;
    check("div_done_cycle_stall", stall_d_o[0], 1);
    tick(); long_done = 1'b0; #1;
    check("div_released", stall_d_o[0], 0);
    check("div_idle", sb_busy_o[0], 0);

    // Structural stall, issue-while-busy error, branch overriding sb stall.
    tick(); clear_inputs(); long_issue_e = 1'b1; rd_e = 5'd8;
    tick(); long_issue_e = 1'b0; rd_e = 5'd0; long_op_d = 1'b1; #1;
    check("struct_stall", stall_d_o[0], 1);
    tick(); long_op_d = 1'b0; long_issue_e = 1'b1; rd_e = 5'd9;
    tick(); long_issue_e = 1'b0; rd_e = 5'd0; #1;
    check("issue_busy_err", sb_err_o[0], 1);
    check("issue_busy_rd_kept", sb_rd_o[0], 8);
    rs1_d = 5'd8; pc_src_e = 1'b1; #1;
    check("br_flush_d", flush_d_o[0], 1);
    check("br_flush_e", flush_e_o[0], 1);
    check("br_stall_f", stall_f_o[0], 0);
    check("br_stall_d", stall_d_o[0], 0);
    tick(); pc_src_e = 1'b0; rs1_d = 5'd0; long_done = 1'b1;
    tick(); long_done = 1'b0; #1;
    check("err_sticky", sb_err_o[0], 1);
    check("err_done_idle", sb_busy_o[0], 0);

    // No-forward instance: producer in MEM stalls ID, released once in WB.
    tick(); clear_inputs(); regwrite_m = 1'b1; rd_m = 5'd3; rs1_d = 5'd3; rs1_e = 5'd3; #1;
    check("nf_stall", stall_d_o[1], 1);
    check("nf_fwd", fwd_a_o[1], 2'b00);
    check("fw_no_stall", stall_d_o[0], 0);
    tick(); regwrite_m = 1'b0; regwrite_w = 1'b1; rd_w = 5'd3; #1;
    check("nf_release", stall_d_o[1], 0);

    // Watchdog: busy lasts MAX_LAT+1 cycles after acceptance, then errors.
    tick(); clear_inputs(); reset = 1'b1; #1;
    check("wd_rst_err", sb_err_o[0], 0);
    tick(); reset = 1'b0; long_issue_e = 1'b1; rd_e = 5'd10;
    tick(); long_issue_e = 1'b0; rd_e = 5'd0; #1;
    check("wd_busy", sb_busy_o[0], 1);
    check("wd_no_err_yet", sb_err_o[0], 0);
    n = 1;
    while (sb_busy_o[0] === 1'b1 && n < 100) begin
      tick();
      if (sb_busy_o[0] === 1'b1) n++;
    end
    check("wd_busy_cycles", n, 35);
    check("wd_err", sb_err_o[0], 1);

    // Reset in the middle of a busy period.
    tick(); long_issue_e = 1'b1; rd_e = 5'd11;
    tick(); long_issue_e = 1'b0; rd_e = 5'd0; rs1_d = 5'd11;
    tick(); tick();
    reset = 1'b1; #1;
    check("rst_mid_busy", sb_busy_o[0], 0);
    check("rst_mid_cnt", cnt0, 0);
    check("rst_mid_err", sb_err_o[0], 0);
    tick(); reset = 1'b0; clear_inputs();

    // Randomised traffic over a small register range to force collisions.
    for (int k = 0; k < 3000; k++) begin
      tick();
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
      rd_d  = 5'($urandom_range(0, 7)); regwrite_d = 1'($urandom);
      long_op_d = ($urandom_range(0, 5) == 0);
      rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
      rd_e  = 5'($urandom_range(0, 7)); regwrite_e = 1'($urandom);
      result_src_e = 2'($urandom);
      pc_src_e = ($urandom_range(0, 15) == 0);
      long_issue_e = ($urandom_range(0, 7) == 0);
      long_done = ($urandom_range(0, 9) == 0);
      rd_m = 5'($urandom_range(0, 7)); regwrite_m = 1'($urandom);
      rd_w = 5'($urandom_range(0, 7)); regwrite_w = 1'($urandom);
      reset = ($urandom_range(0, 399) == 0);
    end
    tick();
    reset = 1'b0;
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
